// File: rtl/event_enc_pkg.sv
// Shared constants and helpers for the 4-line event encoder family.
package event_enc_pkg;

  localparam int unsigned N_LINES = 4;
  localparam int unsigned CODE_W  = 2;

  // Line n encodes to binary n; kept as a function so variants can remap.
  function automatic logic [CODE_W-1:0] line_to_code(input logic [CODE_W-1:0] line);
    return line;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way arbiter: round-robin from ptr+1, or fixed priority (line 0 highest).
module rr_arbiter4
  import event_enc_pkg::*;
(
  input  logic [N_LINES-1:0] pending_i,
  input  logic [CODE_W-1:0]  ptr_i,
  input  logic               rr_mode_i,
  output logic [CODE_W-1:0]  grant_o,
  output logic               grant_valid_o
);

  logic [CODE_W-1:0] base;
  logic [CODE_W-1:0] idx;

  // Fixed priority is round-robin with the pointer pinned at 3. Candidates are
  // visited lowest priority first so the highest-priority hit is written last.
  always_comb begin
    base          = rr_mode_i ? ptr_i : CODE_W'(3);
    idx           = '0;
    grant_o       = '0;
    grant_valid_o = |pending_i;
    for (int unsigned k = 0; k < N_LINES; k++) begin
      idx = base + CODE_W'(N_LINES - k);
      if (pending_i[idx]) grant_o = idx;
    end
  end

endmodule

// File: rtl/event_encoder_4to2.sv
// Captures rising edges on d0..d3 into sticky pending bits and emits each as a
// 2-bit code on a valid/ready handshake; lost events raise a sticky ovf flag.
module event_encoder_4to2
  import event_enc_pkg::*;
#(
  parameter bit RR_MODE = 1'b1,
  parameter bit SYNC_IN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d0,
  input  logic       d1,
  input  logic       d2,
  input  logic       d3,
  input  logic       ready,
  input  logic       clr_ovf,
  output logic       i0,
  output logic       i1,
  output logic       valid,
  output logic [3:0] pending,
  output logic       ovf
);

  logic [N_LINES-1:0] d_w, s, s_q, rise;
  logic [N_LINES-1:0] pend_q, pend_d, gnt_1h;
  logic [1:0]         arm_q;
  logic               armed;
  logic [CODE_W-1:0]  code_q, ptr_q, gnt_idx;
  logic               gnt_v, load, fire;
  logic               valid_q, ovf_q, ovf_d, ovf_set;

  assign d_w = {d3, d2, d1, d0};

  if (SYNC_IN) begin : g_sync
    logic [N_LINES-1:0] sync_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '0;
      else     sync_q <= d_w;
    end
    assign s = sync_q;
  end else begin : g_nosync
    assign s = d_w;
  end

  // History resets to 0, so edges are masked until it has caught up with s;
  // that keeps a line held high through reset from looking like a new event.
  assign armed = SYNC_IN ? arm_q[1] : arm_q[0];
  assign rise  = s & ~s_q & {N_LINES{armed}};

  rr_arbiter4 u_arb (
    .pending_i     (pend_q),
    .ptr_i         (ptr_q),
    .rr_mode_i     (RR_MODE),
    .grant_o       (gnt_idx),
    .grant_valid_o (gnt_v)
  );

  always_comb begin
    load    = !valid_q || ready;
    fire    = load && gnt_v;
    gnt_1h  = fire ? (N_LINES'(1) << gnt_idx) : '0;
    pend_d  = (pend_q & ~gnt_1h) | rise;
    ovf_set = |(rise & pend_q & ~gnt_1h);
    ovf_d   = ovf_set | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q     <= '0;
      arm_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      code_q  <= '0;
      ptr_q   <= CODE_W'(3);
    end else begin
      s_q    <= s;
      arm_q  <= {arm_q[0], 1'b1};
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      if (fire) begin
        code_q  <= line_to_code(gnt_idx);
        valid_q <= 1'b1;
        ptr_q   <= gnt_idx;
      end else if (valid_q && ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign i0      = code_q[0];
  assign i1      = code_q[1];
  assign valid   = valid_q;
  assign pending = pend_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_event_encoder_4to2.sv
// Directed bench: fixed-priority and round-robin instances without input sync,
// plus a default-parameter (round-robin, synchronised) instance.
module tb_event_encoder_4to2;

  logic clk = 1'b0;
  logic rst, d0, d1, d2, d3, ready, clr_ovf;

  logic       a_i0, a_i1, a_valid, a_ovf;
  logic [3:0] a_pend;
  logic       b_i0, b_i1, b_valid, b_ovf;
  logic [3:0] b_pend;
  logic       c_i0, c_i1, c_valid, c_ovf;
  logic [3:0] c_pend;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  event_encoder_4to2 #(.RR_MODE(1'b0), .SYNC_IN(1'b0)) dut_a (
    .clk(clk), .rst(rst), .d0(d0), .d1(d1), .d2(d2), .d3(d3), .ready(ready),
    .clr_ovf(clr_ovf), .i0(a_i0), .i1(a_i1), .valid(a_valid), .pending(a_pend), .ovf(a_ovf));

  event_encoder_4to2 #(.RR_MODE(1'b1), .SYNC_IN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .d0(d0), .d1(d1), .d2(d2), .d3(d3), .ready(ready),
    .clr_ovf(clr_ovf), .i0(b_i0), .i1(b_i1), .valid(b_valid), .pending(b_pend), .ovf(b_ovf));

  event_encoder_4to2 #(.RR_MODE(1'b1), .SYNC_IN(1'b1)) dut_c (
    .clk(clk), .rst(rst), .d0(d0), .d1(d1), .d2(d2), .d3(d3), .ready(ready),
    .clr_ovf(clr_ovf), .i0(c_i0), .i1(c_i1), .valid(c_valid), .pending(c_pend), .ovf(c_ovf));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [3:0] v);
    {d3, d2, d1, d0} = v;
  endtask

  task automatic do_reset();
    set_d(4'b0000);
    ready = 1'b1;
    clr_ovf = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({a_valid, a_i1, a_i0, a_pend, a_ovf} !== 8'b0) begin
      n_errors++;
      $display("FAIL reset_a: got v=%b code=%b%b pend=%b ovf=%b, want all zero",
               a_valid, a_i1, a_i0, a_pend, a_ovf);
    end
    n_checks++;
    if ({c_valid, c_i1, c_i0, c_pend, c_ovf} !== 8'b0) begin
      n_errors++;
      $display("FAIL reset_c: got v=%b code=%b%b pend=%b ovf=%b, want all zero",
               c_valid, c_i1, c_i0, c_pend, c_ovf);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_d(4'b0100);
    tick();
    n_checks++;
    if ({a_valid, a_pend} !== 5'b0_0100) begin
      n_errors++;
      $display("FAIL single_pend: got v=%b pend=%b, want v=0 pend=0100", a_valid, a_pend);
    end
    tick();
    n_checks++;
    if ({a_valid, a_i1, a_i0, a_pend, a_ovf} !== 8'b1_10_0000_0) begin
      n_errors++;
      $display("FAIL single_out: got v=%b code=%b%b pend=%b ovf=%b, want v=1 code=10 pend=0000 ovf=0",
               a_valid, a_i1, a_i0, a_pend, a_ovf);
    end
    tick();  // d2 still high: no second event
    n_checks++;
    if ({a_valid, a_pend} !== 5'b0_0000) begin
      n_errors++;
      $display("FAIL single_held: got v=%b pend=%b, want v=0 pend=0000", a_valid, a_pend);
    end
    set_d(4'b0000);
  endtask

  task automatic test_sync_latency();
    do_reset();
    set_d(4'b0100);
    tick();
    n_checks++;
    if ({c_valid, c_pend} !== 5'b0_0000) begin
      n_errors++;
      $display("FAIL sync_lat1: got v=%b pend=%b, want v=0 pend=0000", c_valid, c_pend);
    end
    tick();
    n_checks++;
    if ({c_valid, c_pend} !== 5'b0_0100) begin
      n_errors++;
      $display("FAIL sync_lat2: got v=%b pend=%b, want v=0 pend=0100", c_valid, c_pend);
    end
    tick();
    n_checks++;
    if ({c_valid, c_i1, c_i0} !== 3'b1_10) begin
      n_errors++;
      $display("FAIL sync_lat3: got v=%b code=%b%b, want v=1 code=10", c_valid, c_i1, c_i0);
    end
    set_d(4'b0000);
  endtask

  task automatic test_simultaneous_fixed();
    logic [6:0] exp_t [6] = '{7'b0_00_1111, 7'b1_00_1110, 7'b1_01_1100,
                              7'b1_10_1000, 7'b1_11_0000, 7'b0_11_0000};
    do_reset();
    set_d(4'b1111);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) set_d(4'b0000);
      n_checks++;
      if ({a_valid, a_i1, a_i0, a_pend} !== exp_t[i]) begin
        n_errors++;
        $display("FAIL simul_fixed[%0d]: got v/code/pend=%b, want %b", i,
                 {a_valid, a_i1, a_i0, a_pend}, exp_t[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    // per step: drive d, then after the edge expect {valid, code, pending}
    logic [3:0] drv_t [12] = '{4'b0010, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b0100,
                               4'b0000, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [6:0] exp_t [12] = '{7'b0_00_0010, 7'b1_01_0000, 7'b0_01_0101, 7'b1_10_0001,
                               7'b1_00_0000, 7'b0_00_0100, 7'b1_10_0000, 7'b0_10_1011,
                               7'b1_11_0011, 7'b1_00_0010, 7'b1_01_0000, 7'b0_01_0000};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      set_d(drv_t[i]);
      tick();
      n_checks++;
      if ({b_valid, b_i1, b_i0, b_pend} !== exp_t[i]) begin
        n_errors++;
        $display("FAIL round_robin[%0d]: got v/code/pend=%b, want %b", i,
                 {b_valid, b_i1, b_i0, b_pend}, exp_t[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_d(4'b0010);
    tick();
    set_d(4'b0000);
    ready = 1'b0;
    tick();
    set_d(4'b1000);
    tick();
    set_d(4'b0000);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({a_valid, a_i1, a_i0, a_pend} !== 7'b1_01_1000) begin
        n_errors++;
        $display("FAIL backpressure_hold[%0d]: got v/code/pend=%b, want 1_01_1000", i,
                 {a_valid, a_i1, a_i0, a_pend});
      end
      tick();
    end
    ready = 1'b1;
    tick();
    n_checks++;
    if ({a_valid, a_i1, a_i0, a_pend} !== 7'b1_11_0000) begin
      n_errors++;
      $display("FAIL backpressure_next: got v/code/pend=%b, want 1_11_0000",
               {a_valid, a_i1, a_i0, a_pend});
    end
    tick();
    n_checks++;
    if (a_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL backpressure_drop: got v=%b, want 0", a_valid);
    end
  endtask

  task automatic test_overflow();
    int ones_seen = 0;
    do_reset();
    ready = 1'b0;
    set_d(4'b0001); tick();
    set_d(4'b0000); tick();   // 00 loaded and held
    set_d(4'b0010); tick();   // pending[1]
    set_d(4'b0000); tick();
    set_d(4'b0010); tick();   // second pulse while pending[1]
    n_checks++;
    if ({a_ovf, a_pend} !== 5'b1_0010) begin
      n_errors++;
      $display("FAIL ovf_set: got ovf=%b pend=%b, want ovf=1 pend=0010", a_ovf, a_pend);
    end
    set_d(4'b0000);
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (a_valid && {a_i1, a_i0} == 2'b01) ones_seen++;
    end
    n_checks++;
    if (ones_seen != 1 || a_ovf !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_deliver: got %0d codes 01 ovf=%b, want 1 code ovf=1", ones_seen, a_ovf);
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    n_checks++;
    if (a_ovf !== 1'b0) begin
      n_errors++;
      $display("FAIL ovf_clear: got ovf=%b, want 0", a_ovf);
    end
    // rise on a line at the same edge it is granted keeps the new event
    ready = 1'b0;
    set_d(4'b0001); tick();
    set_d(4'b0000); tick();
    set_d(4'b0010); tick();
    set_d(4'b0000); tick();
    set_d(4'b0010);
    ready = 1'b1;
    tick();
    n_checks++;
    if ({a_valid, a_i1, a_i0, a_pend, a_ovf} !== 8'b1_01_0010_0) begin
      n_errors++;
      $display("FAIL same_edge: got v/code/pend/ovf=%b, want 1_01_0010_0",
               {a_valid, a_i1, a_i0, a_pend, a_ovf});
    end
    set_d(4'b0000);
    tick();
    n_checks++;
    if ({a_valid, a_i1, a_i0, a_pend} !== 7'b1_01_0000) begin
      n_errors++;
      $display("FAIL same_edge_2nd: got v/code/pend=%b, want 1_01_0000",
               {a_valid, a_i1, a_i0, a_pend});
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    ready = 1'b0;
    set_d(4'b0001); tick();
    set_d(4'b0000); tick();
    set_d(4'b0110); tick();
    set_d(4'b0000);
    n_checks++;
    if ({a_valid, a_pend} !== 5'b1_0110) begin
      n_errors++;
      $display("FAIL mid_setup: got v=%b pend=%b, want v=1 pend=0110", a_valid, a_pend);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({a_valid, a_i1, a_i0, a_pend, a_ovf} !== 8'b0) begin
      n_errors++;
      $display("FAIL mid_reset: got v/code/pend/ovf=%b, want 00000000",
               {a_valid, a_i1, a_i0, a_pend, a_ovf});
    end
    set_d(4'b1000);
    ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({a_valid, a_pend, c_valid, c_pend} !== 10'b0) begin
        n_errors++;
        $display("FAIL held_release[%0d]: got a v/pend=%b%b c v/pend=%b%b, want zero", i,
                 a_valid, a_pend, c_valid, c_pend);
      end
    end
    set_d(4'b0000);
  endtask

  initial begin
    rst = 1'b1;
    ready = 1'b1;
    clr_ovf = 1'b0;
    set_d(4'b0000);
    test_reset();
    test_single();
    test_sync_latency();
    test_simultaneous_fixed();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/event_encoder_4to2.md
Name: event_encoder_4to2

Overview:
Inverse of the 2-to-4 decoder. Captures rising-edge events on four one-hot-style lines d0..d3 and turns each into a 2-bit code (i1,i0) presented on a valid/ready output handshake. Events are held in sticky per-line pending bits. The block arbitrates among pending lines by fixed or round-robin priority, so simultaneous or back-to-back events are never silently merged. It sits between event sources (buttons, decoder outputs, status strobes) and any downstream consumer of a binary code.

Parameters:
RR_MODE, 1, 1 = round-robin arbitration among pending lines; 0 = fixed priority, d0 highest, d3 lowest.
SYNC_IN, 1, 1 = one extra input register stage on d0..d3 (adds 1 cycle latency); 0 = d0..d3 are sampled directly.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
d0  input  1  event line 0; encodes to i1,i0 = 0,0
d1  input  1  event line 1; encodes to 0,1
d2  input  1  event line 2; encodes to 1,0
d3  input  1  event line 3; encodes to 1,1
ready  input  1  downstream accepts the code when valid && ready at a clk edge
clr_ovf  input  1  synchronous clear of ovf
i0  output  1  code bit 0
i1  output  1  code bit 1
valid  output  1  code on i1,i0 is valid
pending  output  4  live pending bits, bit n corresponds to line dn
ovf  output  1  sticky: an event was lost

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset: i0=0, i1=0, valid=0, pending=0000, ovf=0. Edge-detect history registers = 0000. Round-robin pointer = 3, so the first search starts at line 0.
- Edge detect: rise[n] = s[n] & ~s_q[n]. s is d (SYNC_IN=0) or d registered once (SYNC_IN=1). s_q is s delayed one clk.
  - A line held high produces exactly one event.
  - A line high during reset does not produce an event at reset release.
- Pending: pending[n] sets at the edge where rise[n]=1. It clears at the edge where line n is granted.
  - Same-edge rise and grant on line n: pending[n] stays 1 (the new event is kept) and ovf is unaffected.
- Overflow: rise[n]=1 while pending[n]=1 and line n is not granted that edge -> ovf <= 1. ovf holds until clr_ovf=1.
  - clr_ovf and a new overflow on the same edge: ovf stays 1 (set wins).
- Output load: when (!valid || ready) and pending != 0, the grant line g is selected. At that edge: {i1,i0} <= g, valid <= 1, pending[g] clears.
- Output drop: when valid && ready and pending == 0, valid <= 0. i1,i0 hold their last value.
- Output hold: while valid && !ready, i1,i0 and valid are stable. No grant occurs.
- Throughput: one code per cycle while ready=1.
- Latency, SYNC_IN=0: d rises before edge t -> pending set at t -> valid with code at t+1. SYNC_IN=1 adds one cycle.
- Arbitration:
  - RR_MODE=0: lowest-index pending line wins.
  - RR_MODE=1: search starts at (ptr+1) mod 4 and wraps 3->0. ptr <= g on each grant.
- No FSM beyond the valid register. Arbitration is combinational over registered pending.
- Reset mid-transfer: all state clears immediately (asynchronous); in-flight codes and pending events are discarded.

Decomposition:
- Package event_enc_pkg holds:
  - line-count constant N_LINES=4 and code width CODE_W=2
  - the function mapping line index to code
- One natural sub-module: rr_arbiter4, taking pending, ptr and mode and returning grant index and grant-valid. It is reusable for future arbitration blocks.

Test Plan:
- Single events: rise d2 at t, ready=1 -> valid=1 with i1,i0=1,0 at t+1 (SYNC_IN=0), pending=0000 afterwards, ovf=0.
- Simultaneous, RR_MODE=0: d0..d3 all rise on the same edge, ready=1 -> codes 00,01,10,11 on four consecutive cycles, then valid=0.
- Round-robin, RR_MODE=1:
  - Grant line 1 first.
  - Then d0 and d2 rise together -> code 10 precedes code 00.
  - ptr wrap 3->0 is verified.
- Backpressure: ready=0 with valid=1 and code 01, d3 rises -> code 01 stable for 5 cycles, pending=1000. Then ready=1 -> 01 accepted, next cycle code 11.
- Overflow: ready=0, pulse d1 twice (second pulse while pending[1]=1) -> ovf=1 and only one 01 is delivered. Then clr_ovf=1 -> ovf=0.
- Reset behaviour:
  - rst asserted mid-stream with pending=0110 and valid=1 -> all outputs 0 immediately.
  - A line held high across reset release produces no event.
